serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that steps a two-half-adder full-adder cell LSB-first.
// The add is started by a start pulse and reported by a one-cycle done pulse.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, busy_q, done_q, carry_q;
    logic             s0, c0, s1, c1, cout_d;

    half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(s0), .c_o(c0));
    half_adder u_ha1 (.a_i(s0),     .b_i(c_q),    .s_o(s1), .c_o(c1));

    assign cout_d = c0 | c1;
    // sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts
    assign res_d = WIDTH'({s1, res_q} >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        c_q     <= cin_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= cout_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        carry_q <= cout_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_out  = busy_q;
    assign done_out  = done_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: checks WIDTH=8 and WIDTH=1 builds against a cycle-phase arithmetic model.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, cin;
    logic [7:0] a, b;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;
    int         tests = 0, fails = 0;
    logic       go = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_in(start), .a_in(a), .b_in(b), .cin_in(cin),
        .busy_out(busy8), .done_out(done8), .sum_out(sum8), .carry_out(carry8));

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_in(start), .a_in(a[0:0]), .b_in(b[0:0]), .cin_in(cin),
        .busy_out(busy1), .done_out(done1), .sum_out(sum1), .carry_out(carry1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase = cycles since the accepting edge (0 = idle); result appears at phase WIDTH+1.
    int         ph8 = 0, ph1 = 0;
    logic [8:0] pend8, res8 = '0;
    logic [1:0] pend1, res1 = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph8 = 0; ph1 = 0; res8 = '0; res1 = '0;
        end else begin
            if (ph8 == 0) begin
                if (start) begin pend8 = {1'b0, a} + {1'b0, b} + 9'(cin); ph8 = 1; end
            end else ph8 = (ph8 == 9) ? 0 : ph8 + 1;
            if (ph1 == 0) begin
                if (start) begin pend1 = 2'(a[0]) + 2'(b[0]) + 2'(cin); ph1 = 1; end
            end else ph1 = (ph1 == 2) ? 0 : ph1 + 1;
            if (ph8 == 9) res8 = pend8;
            if (ph1 == 2) res1 = pend1;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("busy8",  32'(busy8), 32'(ph8 != 0));
            chk("done8",  32'(done8), 32'(ph8 == 9));
            chk("res8",   32'({carry8, sum8}), 32'(res8));
            chk("busy1",  32'(busy1), 32'(ph1 != 0));
            chk("done1",  32'(done1), 32'(ph1 == 2));
            chk("res1",   32'({carry1, sum1}), 32'(res1));
        end
    end

    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                           input logic [8:0] exp, input string nm);
        int n, nb;
        start = 1'b1; a = ta; b = tb2; cin = tc;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 1; nb = 0;
        while (!done8 && n < 30) begin
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
        if (busy8) nb++;
        chk({nm, "_lat"}, 32'(n), 32'd9);
        chk({nm, "_busycyc"}, 32'(nb), 32'd9);
        chk({nm, "_sum"}, 32'({carry8, sum8}), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        go = 1'b1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum", 32'({carry8, sum8}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_add(8'h5A, 8'h33, 1'b0, 9'h08D, "a5a_33");
        run_add(8'hFF, 8'h01, 1'b0, 9'h100, "ff_01");
        run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff_ff_1");

        // starts during RUN and in the DONE cycle must be dropped
        begin
            int nd;
            nd = 0;
            start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (done8) nd++;
                start = (n == 3 || n == 9);
                a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            start = 1'b0;
            chk("busy_ign_dones", 32'(nd), 32'd1);
            chk("busy_ign_sum", 32'({carry8, sum8}), 32'h030);
        end
        run_add(8'h01, 8'h02, 1'b0, 9'h003, "after_ign");

        // reset in the 4th RUN cycle
        begin
            int nd;
            nd = 0;
            start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
            repeat (4) begin @(negedge clk); start = 1'b0; end
            rst_n = 1'b0;
            @(negedge clk);
            chk("mid_rst_busy", 32'(busy8), 32'd0);
            chk("mid_rst_done", 32'(done8), 32'd0);
            chk("mid_rst_sum", 32'({carry8, sum8}), 32'd0);
            rst_n = 1'b1;
            repeat (12) begin @(negedge clk); if (done8) nd++; end
            chk("mid_rst_nodone", 32'(nd), 32'd0);
        end
        run_add(8'h01, 8'h01, 1'b0, 9'h002, "post_rst");

        // WIDTH=1 build: 1+1+1
        begin
            int n;
            start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
            @(negedge clk);
            start = 1'b0; n = 1;
            while (!done1 && n < 10) begin @(negedge clk); n++; end
            chk("w1_lat", 32'(n), 32'd2);
            chk("w1_sum", 32'({carry1, sum1}), 32'd3);
            repeat (10) @(negedge clk);
        end

        // back-to-back with start held high
        begin
            int nd, last;
            nd = 0; last = 0;
            start = 1'b1;
            for (int n = 1; n <= 60; n++) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                @(negedge clk);
                if (done8) begin
                    if (nd > 0) chk("b2b_period", 32'(n - last), 32'd10);
                    nd++; last = n;
                end
            end
            start = 1'b0;
            chk("b2b_count", 32'(nd), 32'd6);
            repeat (12) @(negedge clk);
        end

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(3) == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            rst_n = ($urandom_range(49) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
